// File: rtl/vrf_move_initiator_pkg.sv
// Shared definitions for the VRF move initiator: FSM encoding and staging depth.
package vrf_move_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/vrf_move_fifo.sv
// Small synchronous staging FIFO between the read and write channels.
module vrf_move_fifo
  import vrf_move_initiator_pkg::*;
#(
  parameter int DATA_WIDTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  // Pointers wrap naturally, so BUF_DEPTH must stay a power of two.
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(BUF_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vrf_move_initiator.sv
// Router-side VRF move initiator: reads words from a source range and writes
// them to a destination range through a 2-entry staging buffer.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   MOVE  | read/write channels active until the last word is written
//   DONE  | one-cycle completion pulse
module vrf_move_initiator
  import vrf_move_initiator_pkg::*;
#(
  parameter int VRF_ADDR_WIDTH = 10,
  parameter int VRF_DATA_WIDTH = 1024,
  parameter int LEN_WIDTH      = VRF_ADDR_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [VRF_ADDR_WIDTH-1:0] cmd_src_addr,
  input  logic [VRF_ADDR_WIDTH-1:0] cmd_dst_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  output logic                      busy,
  output logic                      done,
  output logic [VRF_ADDR_WIDTH-1:0] src_addr,
  input  logic [VRF_DATA_WIDTH-1:0] data_arbiter_send,
  output logic                      read_req,
  input  logic                      read_gnt,
  output logic [VRF_ADDR_WIDTH-1:0] dst_addr,
  output logic [VRF_DATA_WIDTH-1:0] data_arbiter_recv,
  output logic                      write_req,
  input  logic                      write_gnt
);

  state_e                    state_q, state_d;
  logic [VRF_ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]      rd_left_q, rd_left_d, wr_left_q, wr_left_d;
  logic                      rdy_q, rdy_d;
  logic                      fifo_full, fifo_empty;
  logic                      push, pop;

  // Requests depend only on registered state, never on the grants.
  assign read_req  = (state_q == ST_MOVE) && (rd_left_q != '0) && !fifo_full;
  assign write_req = (state_q == ST_MOVE) && !fifo_empty;
  assign push      = read_req && read_gnt;
  assign pop       = write_req && write_gnt;
  assign src_addr  = src_q;
  assign dst_addr  = dst_q;
  assign cmd_ready = rdy_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  vrf_move_fifo #(
    .DATA_WIDTH(VRF_DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i(data_arbiter_send),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (data_arbiter_recv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rd_left_q <= '0;
      wr_left_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      rdy_q     <= rdy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && rdy_q) begin
          src_d     = cmd_src_addr;
          dst_d     = cmd_dst_addr;
          rd_left_d = cmd_len;
          wr_left_d = cmd_len;
          state_d   = (cmd_len == '0) ? ST_DONE : ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (push) begin
          src_d     = src_q + VRF_ADDR_WIDTH'(1);
          rd_left_d = rd_left_q - LEN_WIDTH'(1);
        end
        if (pop) begin
          dst_d     = dst_q + VRF_ADDR_WIDTH'(1);
          wr_left_d = wr_left_q - LEN_WIDTH'(1);
          if (wr_left_q == LEN_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Registered ready keeps cmd_ready low while reset is held.
    rdy_d = (state_d == ST_IDLE);
  end

endmodule

// File: tb/tb_vrf_move_initiator.sv
// Bench for vrf_move_initiator: memory-level model of a vector move plus directed scenarios.
module tb_vrf_move_initiator;

  localparam int AW = 10;
  localparam int DW = 1024;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src_addr, cmd_dst_addr;
  logic [LW-1:0] cmd_len;
  logic          busy, done;
  logic [AW-1:0] src_addr, dst_addr;
  logic [DW-1:0] data_arbiter_send, data_arbiter_recv;
  logic          read_req, read_gnt, write_req, write_gnt;

  int total = 0;
  int passed = 0;
  int rd_mode = 1;
  int wr_mode = 1;

  logic [AW-1:0] exp_rd[$];
  logic [AW-1:0] exp_wa[$];
  logic [AW-1:0] exp_ws[$];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_log[$];
  logic [DW-1:0] wd_log[$];
  bit            active = 1'b0;
  bit            exp_done = 1'b0;
  bit            mon_nd;
  int            mon_occ;
  int            post = 0;

  vrf_move_initiator #(
    .VRF_ADDR_WIDTH(AW),
    .VRF_DATA_WIDTH(DW),
    .LEN_WIDTH     (LW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_src_addr     (cmd_src_addr),
    .cmd_dst_addr     (cmd_dst_addr),
    .cmd_len          (cmd_len),
    .busy             (busy),
    .done             (done),
    .src_addr         (src_addr),
    .data_arbiter_send(data_arbiter_send),
    .read_req         (read_req),
    .read_gnt         (read_gnt),
    .dst_addr         (dst_addr),
    .data_arbiter_recv(data_arbiter_recv),
    .write_req        (write_req),
    .write_gnt        (write_gnt)
  );

  always #5 clk = ~clk;

  // Source VRF contents: a recognisable pattern per address and lane.
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < 32; i++) w[i*32 +: 32] = {a, 6'(i), 16'hBEEF};
    return w;
  endfunction

  function automatic logic pick(input int m);
    if (m == 0) return 1'b1;
    if (m == 1) return 1'b0;
    return ($urandom_range(0, 2) != 0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got low64 0x%0h, want low64 0x%0h", nm, act[63:0], exp[63:0]);
  endtask

  // Arbiter side: grants (possibly spurious) and read data, driven after the edge.
  always @(posedge clk) begin
    #1;
    read_gnt          = pick(rd_mode);
    write_gnt         = pick(wr_mode);
    data_arbiter_send = read_gnt ? word_of(src_addr) : ~word_of(src_addr);
  end

  // Compare process: the move is a list of outstanding reads and writes.
  always @(negedge clk) begin
    if (!rst_n) begin
      post = 0;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_read_req", read_req, 0);
      chk("rst_write_req", write_req, 0);
      chk("rst_src_addr", src_addr, 0);
      chk("rst_dst_addr", dst_addr, 0);
      chkd("rst_wdata", data_arbiter_recv, '0);
      exp_rd.delete();
      exp_wa.delete();
      exp_ws.delete();
      active   = 1'b0;
      exp_done = 1'b0;
    end else begin
      post++;
      mon_occ = exp_wa.size() - exp_rd.size();
      chk("busy", busy, active);
      chk("done", done, exp_done);
      chk("cmd_ready", cmd_ready, (post >= 2) && !active);
      chk("read_req", read_req, (exp_rd.size() > 0) && (mon_occ < 2));
      chk("write_req", write_req, mon_occ > 0);
      if (read_req && exp_rd.size() > 0) chk("src_addr", src_addr, exp_rd[0]);
      if (write_req && exp_wa.size() > 0) begin
        chk("dst_addr", dst_addr, exp_wa[0]);
        chkd("wdata", data_arbiter_recv, word_of(exp_ws[0]));
      end
      mon_nd = 1'b0;
      if (exp_done) active = 1'b0;
      if (read_req && read_gnt) begin
        rd_log.push_back(src_addr);
        if (exp_rd.size() > 0) void'(exp_rd.pop_front());
      end
      if (write_req && write_gnt) begin
        wr_log.push_back(dst_addr);
        wd_log.push_back(data_arbiter_recv);
        if (exp_wa.size() > 0) begin
          void'(exp_wa.pop_front());
          void'(exp_ws.pop_front());
          if (exp_wa.size() == 0) mon_nd = 1'b1;
        end
      end
      if (cmd_valid && cmd_ready) begin
        active = 1'b1;
        for (int k = 0; k < int'(cmd_len); k++) begin
          exp_rd.push_back(cmd_src_addr + AW'(k));
          exp_wa.push_back(cmd_dst_addr + AW'(k));
          exp_ws.push_back(cmd_src_addr + AW'(k));
        end
        if (cmd_len == '0) mon_nd = 1'b1;
      end
      exp_done = mon_nd;
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    wd_log.delete();
  endtask

  // Returns in cycle T+1 when the command was accepted in cycle T.
  task automatic send_cmd(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    chk("cmd_ready_wait", ok, 1);
    cmd_src_addr = s;
    cmd_dst_addr = d;
    cmd_len      = n;
    cmd_valid    = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk); #2;
      if (done) begin n = i; found = 1'b1; break; end
    end
    chk("done_seen", found, 1);
  endtask

  logic [AW-1:0] er[3];
  logic [AW-1:0] ew[3];
  int            n;
  bit            hit;

  initial begin
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_src_addr = '0;
    cmd_dst_addr = '0;
    cmd_len      = '0;
    read_gnt     = 1'b0;
    write_gnt    = 1'b0;
    data_arbiter_send = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_busy", busy, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("ready_after_reset", cmd_ready, 1);

    // Basic move, full-rate arbiter.
    rd_mode = 0; wr_mode = 0;
    clear_logs();
    send_cmd(10'h010, 10'h200, 11'd4);
    chk("t1_first_req", read_req, 1);
    chk("t1_first_src", src_addr, 10'h010);
    wait_done(50, n);
    chk("t1_done_latency", n, 5);
    chk("t1_nwrites", wr_log.size(), 4);
    chk("t1_nreads", rd_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_waddr", wr_log[k], 10'h200 + AW'(k));
      chkd("t1_wdata", wd_log[k], word_of(10'h010 + AW'(k)));
    end
    @(posedge clk); #2;
    chk("t1_done_one_cycle", done, 0);
    chk("t1_ready_again", cmd_ready, 1);

    // Zero-length command.
    clear_logs();
    send_cmd(10'h055, 10'h155, 11'd0);
    chk("t2_done_t1", done, 1);
    chk("t2_busy_t1", busy, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("t2_no_reads", rd_log.size(), 0);
    chk("t2_no_writes", wr_log.size(), 0);

    // Address wrap.
    er = '{10'h3FE, 10'h3FF, 10'h000};
    ew = '{10'h3FF, 10'h000, 10'h001};
    clear_logs();
    send_cmd(10'h3FE, 10'h3FF, 11'd3);
    wait_done(50, n);
    chk("t3_nwrites", wr_log.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("t3_raddr", rd_log[k], er[k]);
      chk("t3_waddr", wr_log[k], ew[k]);
    end

    // Write backpressure.
    rd_mode = 0; wr_mode = 1;
    clear_logs();
    send_cmd(10'h120, 10'h2A0, 11'd5);
    repeat (10) @(posedge clk);
    #2;
    chk("t4_reads_held", rd_log.size(), 2);
    chk("t4_read_req_low", read_req, 0);
    chk("t4_write_req", write_req, 1);
    chk("t4_dst_held", dst_addr, 10'h2A0);
    chkd("t4_wdata_held", data_arbiter_recv, word_of(10'h120));
    wr_mode = 0;
    wait_done(100, n);
    chk("t4_nwrites", wr_log.size(), 5);
    chk("t4_last_waddr", wr_log[4], 10'h2A4);
    chkd("t4_last_wdata", wd_log[4], word_of(10'h124));

    // Random grant gaps with spurious grants on both channels.
    rd_mode = 2; wr_mode = 2;
    clear_logs();
    send_cmd(10'h0C0, 10'h1E0, 11'd64);
    wait_done(2000, n);
    chk("t5_nwrites", wr_log.size(), 64);
    chk("t5_nreads", rd_log.size(), 64);
    chkd("t5_word63", wd_log[63], word_of(10'h0FF));

    // Reset in the middle of a move.
    rd_mode = 0; wr_mode = 0;
    clear_logs();
    send_cmd(10'h040, 10'h080, 11'd8);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (wr_log.size() >= 3) begin hit = 1'b1; break; end
    end
    chk("t6_three_writes_seen", hit, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_read_req", read_req, 0);
    chk("t6_write_req", write_req, 0);
    chk("t6_src", src_addr, 0);
    chk("t6_dst", dst_addr, 0);
    chkd("t6_wdata", data_arbiter_recv, '0);
    chk("t6_cmd_ready", cmd_ready, 0);
    chk("t6_writes_at_reset", wr_log.size(), 3);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    clear_logs();
    send_cmd(10'h100, 10'h300, 11'd2);
    wait_done(50, n);
    chk("t6_new_nwrites", wr_log.size(), 2);
    chk("t6_new_waddr0", wr_log[0], 10'h300);
    chk("t6_new_waddr1", wr_log[1], 10'h301);
    chkd("t6_new_wdata1", wd_log[1], word_of(10'h101));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
